instruction_fetch: RTL and testbench

- Fetch stage directly upstream of the instruction decoder. Owns the program counter and issues word requests to instruction memory over a req/gnt/rvalid interface.
- Buffers returned words with their PCs and presents {instruction, pc} to the decoder over a valid/ready handshake.
- Handles redirects from branch/jump resolution by flushing buffered words and discarding in-flight responses.

---
 rtl/instruction_fetch_pkg.sv | 22 ++
 rtl/instruction_fetch_fifo.sv | 67 ++++++
 rtl/instruction_fetch.sv | 124 ++++++++++++
 tb/tb_instruction_fetch.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instruction_fetch_pkg : shared types and constants for the fetch stage     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package instruction_fetch_pkg;

  localparam int unsigned XLEN             = 32;
  localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sync_fifo : synchronous FIFO with flush, full/empty flags and occupancy    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];
  assign w_pop   = i_pop && !o_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push  = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (i_push && !i_flush) |-> (!o_full || i_pop));

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instruction_fetch : PC owner, imem request issue and decoder-side buffer   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] c_credit_max = (CW + 1)'(DEPTH);

  logic [31:0]   r_fetch_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;

  logic [CW:0]   w_credit;
  logic [CW-1:0] w_out_count;
  logic [CW-1:0] w_pend_count;
  logic [31:0]   w_pend_pc;
  logic          w_pend_full, w_pend_empty, w_out_full, w_out_empty;
  logic          w_handshake, w_req, w_grant, w_rvalid, w_keep;
  fetch_entry_t  w_push_entry, w_head;

  assign w_handshake = instr_valid_o && instr_ready_i;
  assign w_credit    = {1'b0, r_outstanding} + {1'b0, w_out_count};
  // Popping the head frees the slot the next response lands in, so a full
  // credit window may still issue while the decoder is draining.
  assign w_req       = !rst_i && !redirect_i &&
                       ((w_credit < c_credit_max) ||
                        ((w_credit == c_credit_max) && w_handshake));
  assign w_grant     = w_req && imem_gnt_i;
  assign w_rvalid    = imem_rvalid_i && !rst_i;
  assign w_keep      = w_rvalid && (r_discard == '0) && !redirect_i;

  assign imem_req_o  = w_req;
  assign imem_addr_o = r_fetch_pc;

  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_pending_pc (
    .clk     (clk_i),
    .rst     (rst_i),
    .i_push  (w_grant),
    .i_wdata (r_fetch_pc),
    .i_pop   (w_keep),
    .i_flush (redirect_i),
    .o_rdata (w_pend_pc),
    .o_full  (w_pend_full),
    .o_empty (w_pend_empty),
    .o_count (w_pend_count)
  );

  assign w_push_entry = '{pc: w_pend_pc, instr: imem_rdata_i};

  sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_out_fifo (
    .clk     (clk_i),
    .rst     (rst_i),
    .i_push  (w_keep),
    .i_wdata (w_push_entry),
    .i_pop   (w_handshake),
    .i_flush (redirect_i),
    .o_rdata (w_head),
    .o_full  (w_out_full),
    .o_empty (w_out_empty),
    .o_count (w_out_count)
  );

  assign instr_valid_o = !w_out_empty;
  assign instruction_o = instr_valid_o ? w_head.instr : INSTR_NOP;
  assign pc_o          = instr_valid_o ? w_head.pc    : 32'h0000_0000;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      case ({w_grant, w_rvalid})
        2'b10:   r_outstanding <= r_outstanding + CW'(1);
        2'b01:   r_outstanding <= r_outstanding - CW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
      if (redirect_i) begin
        r_fetch_pc <= align_word(redirect_pc_i);
        // Every response still owed at flush time belongs to the old path.
        r_discard  <= w_rvalid ? r_outstanding - CW'(1) : r_outstanding;
      end else begin
        if (w_grant) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_rvalid && (r_discard != '0)) r_discard <= r_discard - CW'(1);
      end
    end
  end

  a_rvalid_owed: assert property (@(posedge clk_i) disable iff (rst_i)
    imem_rvalid_i |-> (r_outstanding != '0));
  a_addr_aligned: assert property (@(posedge clk_i) disable iff (rst_i)
    imem_addr_o[1:0] == 2'b00);
  a_pending_tracks: assert property (@(posedge clk_i) disable iff (rst_i)
    w_pend_count == (r_outstanding - r_discard));
  a_pending_room: assert property (@(posedge clk_i) disable iff (rst_i)
    !(w_grant && w_pend_full));
  a_keep_has_pc: assert property (@(posedge clk_i) disable iff (rst_i)
    w_keep |-> !w_pend_empty);
  a_out_room: assert property (@(posedge clk_i) disable iff (rst_i)
    w_keep |-> (!w_out_full || w_handshake));

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_instruction_fetch : randomized bench with in-order memory and stream    |
// | reference model for instruction_fetch                                      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_instruction_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] KEY    = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst, gnt, rvalid, redirect, ready;
  logic [31:0] rdata, redirect_pc;
  logic        req, valid;
  logic [31:0] addr, instr, pc;

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .imem_req_o    (req),
    .imem_addr_o   (addr),
    .imem_gnt_i    (gnt),
    .imem_rvalid_i (rvalid),
    .imem_rdata_i  (rdata),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .instr_valid_o (valid),
    .instr_ready_i (ready),
    .instruction_o (instr),
    .pc_o          (pc)
  );

  // Memory model: granted words in order, each tagged with the redirect epoch
  // it was fetched in; only current-epoch words may reach the decoder.
  typedef struct {
    logic [31:0] a;
    int          due;
    int          ep;
  } mreq_t;

  mreq_t       mq[$];
  int          checks = 0, errors = 0;
  int          cyc = 0, epoch = 0, buffered = 0, delivered = 0;
  int          first_req = -1, first_valid = -1;
  int          gnt_pct = 100, ready_pct = 100, redir_pct = 0, max_lat = 0;
  logic [31:0] exp_pc = RST_PC;
  logic        force_redir = 1'b0;
  logic [31:0] force_tgt = '0;
  logic        saw_wrap = 1'b0;
  logic        p_valid = 1'b0, p_ready = 1'b0, p_redir = 1'b0, p_req = 1'b0, p_gnt = 1'b0;
  logic [31:0] p_addr = '0, p_instr = '0, p_pc = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic hs, grant, kept;
    int   credit;
    gnt      = ($urandom_range(99) < gnt_pct);
    ready    = ($urandom_range(99) < ready_pct);
    redirect = force_redir || ($urandom_range(99) < redir_pct);
    redirect_pc = force_redir ? force_tgt : ($urandom & 32'h0000_FFFF);
    force_redir = 1'b0;
    rvalid   = (mq.size() > 0) && (mq[0].due <= cyc);
    rdata    = rvalid ? (mq[0].a ^ KEY) : $urandom;
    #3;
    credit = mq.size() + buffered;
    check("req_rule", req, !redirect && ((credit < DEPTH) || ((credit == DEPTH) && valid && ready)));
    check("valid", valid, buffered != 0);
    check("credit_bound", credit <= DEPTH, 1);
    check("addr_align", addr[1:0], 0);
    if (p_req && !p_gnt && !p_redir) check("addr_hold", addr, p_addr);
    if (p_redir) check("valid_after_redirect", valid, 0);
    if (p_valid && !p_ready && !p_redir) begin
      check("hold_pc", pc, p_pc);
      check("hold_instr", instr, p_instr);
    end
    if (req && first_req < 0) first_req = cyc;
    if (valid && first_valid < 0) first_valid = cyc;
    hs = valid && ready;
    if (hs) begin
      check("stream_pc", pc, exp_pc);
      check("stream_instr", instr, exp_pc ^ KEY);
      if (exp_pc == 32'h0) saw_wrap = 1'b1;
      exp_pc = exp_pc + 32'd4;
      buffered--;
      delivered++;
    end
    grant = req && gnt;
    if (rvalid) begin
      kept = (mq[0].ep == epoch) && !redirect;
      void'(mq.pop_front());
      if (kept) buffered++;
    end
    if (grant) mq.push_back('{a: addr, due: cyc + 1 + $urandom_range(max_lat), ep: epoch});
    if (redirect) begin
      epoch++;
      buffered = 0;
      exp_pc   = {redirect_pc[31:2], 2'b00};
    end
    p_valid = valid; p_ready = ready; p_redir = redirect;
    p_req = req; p_gnt = gnt; p_addr = addr; p_instr = instr; p_pc = pc;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; gnt = 1'b0; rvalid = 1'b0; redirect = 1'b0; ready = 1'b0;
    redirect_pc = '0; rdata = '0;
    #3;
    check("req_in_reset", req, 0);
    @(posedge clk);
    #1;
    check("rst_valid", valid, 0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_pc", pc, 32'h0);
    check("rst_req", req, 0);
    for (int i = 1; i < n; i++) begin @(posedge clk); #1; end
    mq.delete();
    buffered = 0; epoch++; exp_pc = RST_PC; delivered = 0;
    first_req = -1; first_valid = -1; cyc = 0;
    p_valid = 0; p_ready = 0; p_redir = 0; p_req = 0; p_gnt = 0;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; gnt = 1'b0; rvalid = 1'b0; redirect = 1'b0; ready = 1'b0;
    redirect_pc = '0; rdata = '0;
    @(posedge clk);
    #1;
    do_reset(2);

    // Zero-wait memory: latency and full throughput.
    gnt_pct = 100; ready_pct = 100; max_lat = 0; redir_pct = 0;
    run(20);
    check("first_req_cycle", first_req, 0);
    check("first_valid_latency", first_valid - first_req, 2);
    check("throughput", delivered, 18);

    // Decoder stall then resume.
    ready_pct = 0;   run(5);
    ready_pct = 100; run(8);

    // Memory refuses grants: address must hold.
    gnt_pct = 0;   run(3);
    gnt_pct = 100; run(6);

    // Redirect with responses in flight, unaligned target.
    max_lat = 3; run(4);
    force_redir = 1'b1; force_tgt = 32'h0000_0103;
    run(12);

    // Redirect in steady state: coincides with rvalid and handshake.
    max_lat = 0; run(5);
    force_redir = 1'b1; force_tgt = 32'h0000_0200;
    run(8);

    // Randomized mix.
    for (int b = 0; b < 4; b++) begin
      gnt_pct   = 40 + 20 * b;
      ready_pct = 90 - 20 * b;
      redir_pct = 3 + 4 * b;
      max_lat   = b;
      run(400);
    end
    redir_pct = 0;

    // Fill the FIFO, then reset mid-stream.
    gnt_pct = 100; ready_pct = 0; max_lat = 0;
    run(6);
    check("full_before_reset", valid, 1);
    do_reset(2);
    gnt_pct = 100; ready_pct = 100;
    run(6);

    // PC wrap at the top of the address space.
    saw_wrap = 1'b0;
    force_redir = 1'b1; force_tgt = 32'hFFFF_FFF8;
    run(12);
    check("pc_wrap_seen", saw_wrap, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
